// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU op encodings and operand-select constants for the ID/EX stage.
package id_ex_stage_pkg;

  localparam int ID_EX_DW  = 32;
  localparam int ID_EX_RW  = 5;
  localparam int ID_EX_OPW = 4;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  localparam logic A_SEL_RS    = 1'b0;
  localparam logic A_SEL_SHAMT = 1'b1;
  localparam logic B_SEL_RT    = 1'b0;
  localparam logic B_SEL_IMM   = 1'b1;

  typedef enum logic [1:0] {
    UPD_CAPTURE,
    UPD_HOLD,
    UPD_BUBBLE
  } upd_e;

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Per-source forwarding: EX/MEM beats MEM/WB beats the stored regfile value; $0 never forwards.
module ex_forward_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = ID_EX_DW,
  parameter int RW = ID_EX_RW
) (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] stored_val,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] fwd_val,
  output logic          exmem_hit,
  output logic          memwb_hit
);

  assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src);
  assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src);

  always_comb begin
    fwd_val = stored_val;
    if (exmem_hit) begin
      fwd_val = exmem_result;
    end else if (memwb_hit) begin
      fwd_val = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarded ALU operands, load-use detection and bubble insertion.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW  = ID_EX_DW,
  parameter int RW  = ID_EX_RW,
  parameter int OPW = ID_EX_OPW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [DW-1:0]  id_pc,
  input  logic [DW-1:0]  id_rs_val,
  input  logic [DW-1:0]  id_rt_val,
  input  logic [DW-1:0]  id_imm,
  input  logic [RW-1:0]  id_shamt,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic [RW-1:0]  id_rd,
  input  logic [OPW-1:0] id_alu_op,
  input  logic           id_a_sel,
  input  logic           id_b_sel,
  input  logic           id_reg_write,
  input  logic           id_mem_read,
  input  logic           id_mem_write,
  input  logic           stall,
  input  logic           flush,
  input  logic           exmem_reg_write,
  input  logic [RW-1:0]  exmem_rd,
  input  logic [DW-1:0]  exmem_result,
  input  logic           memwb_reg_write,
  input  logic [RW-1:0]  memwb_rd,
  input  logic [DW-1:0]  memwb_result,
  output logic           load_use_stall,
  output logic           ex_valid,
  output logic [DW-1:0]  ex_pc,
  output logic [DW-1:0]  ex_alu_a,
  output logic [DW-1:0]  ex_alu_b,
  output logic [OPW-1:0] ex_alu_op,
  output logic [DW-1:0]  ex_store_data,
  output logic [RW-1:0]  ex_rd,
  output logic           ex_reg_write,
  output logic           ex_mem_read,
  output logic           ex_mem_write
);

  logic           valid_q, valid_d;
  logic [DW-1:0]  pc_q, pc_d;
  logic [DW-1:0]  rs_val_q, rs_val_d;
  logic [DW-1:0]  rt_val_q, rt_val_d;
  logic [DW-1:0]  imm_q, imm_d;
  logic [RW-1:0]  shamt_q, shamt_d;
  logic [RW-1:0]  rs_q, rs_d;
  logic [RW-1:0]  rt_q, rt_d;
  logic [RW-1:0]  rd_q, rd_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic           a_sel_q, a_sel_d;
  logic           b_sel_q, b_sel_d;
  logic           reg_write_q, reg_write_d;
  logic           mem_read_q, mem_read_d;
  logic           mem_write_q, mem_write_d;

  logic [DW-1:0]  fwd_rs, fwd_rt;
  logic           rs_exmem_hit, rs_memwb_hit, rt_exmem_hit, rt_memwb_hit;
  logic           unused_exmem_hits;
  upd_e           upd;

  ex_forward_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src             (rs_q),
    .stored_val      (rs_val_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_val         (fwd_rs),
    .exmem_hit       (rs_exmem_hit),
    .memwb_hit       (rs_memwb_hit)
  );

  ex_forward_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src             (rt_q),
    .stored_val      (rt_val_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_val         (fwd_rt),
    .exmem_hit       (rt_exmem_hit),
    .memwb_hit       (rt_memwb_hit)
  );

  assign unused_exmem_hits = rs_exmem_hit ^ rt_exmem_hit;

  assign load_use_stall = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                          ((rd_q == id_rs) || (rd_q == id_rt));

  always_comb begin
    upd = UPD_CAPTURE;
    if (flush) begin
      upd = UPD_BUBBLE;
    end else if (stall) begin
      upd = UPD_HOLD;
    end else if (load_use_stall) begin
      upd = UPD_BUBBLE;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs_val_d    = rs_val_q;
    rt_val_d    = rt_val_q;
    imm_d       = imm_q;
    shamt_d     = shamt_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    alu_op_d    = alu_op_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    case (upd)
      UPD_BUBBLE: begin
        valid_d     = 1'b0;
        pc_d        = '0;
        rs_val_d    = '0;
        rt_val_d    = '0;
        imm_d       = '0;
        shamt_d     = '0;
        rs_d        = '0;
        rt_d        = '0;
        rd_d        = '0;
        alu_op_d    = '0;
        a_sel_d     = 1'b0;
        b_sel_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
      UPD_HOLD: begin
        // Writebacks retiring while EX is frozen would otherwise be lost.
        if (rs_memwb_hit) rs_val_d = memwb_result;
        if (rt_memwb_hit) rt_val_d = memwb_result;
      end
      default: begin
        valid_d     = id_valid;
        pc_d        = id_pc;
        rs_val_d    = id_rs_val;
        rt_val_d    = id_rt_val;
        imm_d       = id_imm;
        shamt_d     = id_shamt;
        rs_d        = id_rs;
        rt_d        = id_rt;
        rd_d        = id_rd;
        alu_op_d    = id_alu_op;
        a_sel_d     = id_a_sel;
        b_sel_d     = id_b_sel;
        reg_write_d = id_valid && id_reg_write;
        mem_read_d  = id_valid && id_mem_read;
        mem_write_d = id_valid && id_mem_write;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      imm_q       <= imm_d;
      shamt_q     <= shamt_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      alu_op_q    <= alu_op_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_alu_a      = (a_sel_q == A_SEL_SHAMT) ? {{(DW-RW){1'b0}}, shamt_q} : fwd_rs;
  assign ex_alu_b      = (b_sel_q == B_SEL_IMM) ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against an instruction-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_a_sel, id_b_sel, id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        load_use_stall, ex_valid;
  logic [31:0] ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_op(ex_alu_op),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs_val, rt_val, imm;
    logic [4:0]  shamt, rs, rt, rd;
    logic [3:0]  op;
    logic        a_sel, b_sel, rw, mr, mw;
  } instr_t;

  instr_t m;

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 0; b.pc = 0; b.rs_val = 0; b.rt_val = 0; b.imm = 0;
    b.shamt = 0; b.rs = 0; b.rt = 0; b.rd = 0; b.op = 0;
    b.a_sel = 0; b.b_sel = 0; b.rw = 0; b.mr = 0; b.mw = 0;
    return b;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] stored);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == src) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == src) return memwb_result;
    return stored;
  endfunction

  function automatic logic exp_lus();
    return m.valid && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs || m.rd == id_rt);
  endfunction

  function automatic instr_t model_next();
    instr_t n;
    n = m;
    if (!rst_n || flush) begin
      n = bubble();
    end else if (stall) begin
      if (memwb_reg_write && memwb_rd != 0 && memwb_rd == m.rs) n.rs_val = memwb_result;
      if (memwb_reg_write && memwb_rd != 0 && memwb_rd == m.rt) n.rt_val = memwb_result;
    end else if (exp_lus()) begin
      n = bubble();
    end else begin
      n.valid = id_valid; n.pc = id_pc; n.rs_val = id_rs_val; n.rt_val = id_rt_val;
      n.imm = id_imm; n.shamt = id_shamt; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
      n.op = id_alu_op; n.a_sel = id_a_sel; n.b_sel = id_b_sel;
      n.rw = id_valid & id_reg_write; n.mr = id_valid & id_mem_read; n.mw = id_valid & id_mem_write;
    end
    return n;
  endfunction

  task automatic tick();
    instr_t nx;
    nx = model_next();
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_pc = 0; id_rs_val = 0; id_rt_val = 0; id_imm = 0;
    id_shamt = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_alu_op = 0;
    id_a_sel = 0; id_b_sel = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    stall = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    id_valid = 1; id_rs_val = 32'hDEAD; id_reg_write = 1;
    tick(); tick();
    rst_n = 1;
    clear_inputs();
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", ex_valid); end
    total++; if (ex_alu_a !== 32'h0) begin bad++; $display("FAIL reset_alu_a got=%h want=0", ex_alu_a); end
    total++; if (ex_alu_b !== 32'h0) begin bad++; $display("FAIL reset_alu_b got=%h want=0", ex_alu_b); end
    total++; if (ex_store_data !== 32'h0) begin bad++; $display("FAIL reset_store got=%h want=0", ex_store_data); end
    total++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000) begin bad++;
      $display("FAIL reset_ctrl got=%b want=000", {ex_reg_write, ex_mem_read, ex_mem_write}); end
  endtask

  task automatic test_capture();
    id_valid = 1; id_pc = 32'h100; id_rs = 1; id_rt = 2; id_rd = 3;
    id_rs_val = 5; id_rt_val = 7; id_alu_op = 4'b0000; id_reg_write = 1;
    tick();
    clear_inputs();
    #1;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL cap_valid got=%0b want=1", ex_valid); end
    total++; if (ex_alu_a !== 32'd5) begin bad++; $display("FAIL cap_alu_a got=%h want=5", ex_alu_a); end
    total++; if (ex_alu_b !== 32'd7) begin bad++; $display("FAIL cap_alu_b got=%h want=7", ex_alu_b); end
    total++; if (ex_pc !== 32'h100) begin bad++; $display("FAIL cap_pc got=%h want=100", ex_pc); end
    total++; if (ex_rd !== 5'd3 || ex_reg_write !== 1'b1) begin bad++;
      $display("FAIL cap_rd got=%0d/%0b want=3/1", ex_rd, ex_reg_write); end
  endtask

  task automatic test_forward_priority();
    id_valid = 1; id_rs = 3; id_rs_val = 32'h11; id_rt = 9; id_rt_val = 32'h22;
    tick();
    clear_inputs();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
    #1;
    total++; if (ex_alu_a !== 32'hAA) begin bad++; $display("FAIL fwd_exmem got=%h want=aa", ex_alu_a); end
    exmem_reg_write = 0;
    #1;
    total++; if (ex_alu_a !== 32'hBB) begin bad++; $display("FAIL fwd_memwb got=%h want=bb", ex_alu_a); end
    memwb_reg_write = 0;
    #1;
    total++; if (ex_alu_a !== 32'h11) begin bad++; $display("FAIL fwd_none got=%h want=11", ex_alu_a); end
  endtask

  task automatic test_zero_reg();
    id_valid = 1; id_rs = 0; id_rs_val = 0; id_rt = 0; id_rt_val = 0;
    tick();
    clear_inputs();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFF;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hEE;
    #1;
    total++; if (ex_alu_a !== 32'h0) begin bad++; $display("FAIL zero_a got=%h want=0", ex_alu_a); end
    total++; if (ex_store_data !== 32'h0) begin bad++; $display("FAIL zero_st got=%h want=0", ex_store_data); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    id_valid = 1; id_rs = 1; id_rd = 4; id_rt = 4; id_b_sel = 1; id_imm = 8;
    id_mem_read = 1; id_reg_write = 1;
    tick();
    clear_inputs();
    id_valid = 1; id_rs = 4; id_rt = 1; id_rd = 5; id_reg_write = 1; id_pc = 32'h200;
    #1;
    total++; if (load_use_stall !== 1'b1) begin bad++; $display("FAIL lu_assert got=%0b want=1", load_use_stall); end
    tick();
    total++; if (ex_valid !== 1'b0 || {ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000) begin bad++;
      $display("FAIL lu_bubble got=%0b/%b want=0/000", ex_valid, {ex_reg_write, ex_mem_read, ex_mem_write}); end
    total++; if (load_use_stall !== 1'b0) begin bad++; $display("FAIL lu_once got=%0b want=0", load_use_stall); end
    tick();
    clear_inputs();
    #1;
    total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_pc !== 32'h200) begin bad++;
      $display("FAIL lu_capture got=%0b/%0d/%h want=1/5/200", ex_valid, ex_rd, ex_pc); end
  endtask

  task automatic test_stall_refresh();
    id_valid = 1; id_rs = 2; id_rt = 6; id_rt_val = 0; id_mem_write = 1; id_pc = 32'h300;
    tick();
    clear_inputs();
    stall = 1; memwb_reg_write = 1; memwb_rd = 6; memwb_result = 32'h1234;
    id_valid = 1; id_pc = 32'h999; id_rd = 7; id_reg_write = 1;
    for (int i = 0; i < 3; i++) tick();
    clear_inputs();
    #1;
    total++; if (ex_store_data !== 32'h1234) begin bad++; $display("FAIL stall_refresh got=%h want=1234", ex_store_data); end
    total++; if (ex_pc !== 32'h300 || ex_mem_write !== 1'b1) begin bad++;
      $display("FAIL stall_hold got=%h/%0b want=300/1", ex_pc, ex_mem_write); end
    flush = 1; stall = 1;
    tick();
    clear_inputs();
    #1;
    total++; if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0 || ex_store_data !== 32'h0) begin bad++;
      $display("FAIL flush_stall got=%0b/%0b/%h want=0/0/0", ex_valid, ex_mem_write, ex_store_data); end
  endtask

  task automatic test_imm_shamt();
    id_valid = 1; id_a_sel = 1; id_shamt = 4; id_b_sel = 1; id_imm = 32'h0000_FFFF;
    id_alu_op = 4'b1011; id_rs = 3; id_rs_val = 32'h55; id_rt = 2; id_rt_val = 32'h66;
    tick();
    clear_inputs();
    #1;
    total++; if (ex_alu_a !== 32'd4) begin bad++; $display("FAIL lui_a got=%h want=4", ex_alu_a); end
    total++; if (ex_alu_b !== 32'h0000_FFFF) begin bad++; $display("FAIL lui_b got=%h want=ffff", ex_alu_b); end
    total++; if (ex_alu_op !== 4'b1011) begin bad++; $display("FAIL lui_op got=%b want=1011", ex_alu_op); end
    total++; if (ex_store_data !== 32'h66) begin bad++; $display("FAIL lui_store got=%h want=66", ex_store_data); end
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, es;
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_pc = $urandom; id_imm = $urandom; id_shamt = 5'($urandom);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      id_rs_val = (id_rs == 0) ? 32'h0 : $urandom;
      id_rt_val = (id_rt == 0) ? 32'h0 : $urandom;
      id_alu_op = 4'($urandom_range(0, 11));
      id_a_sel = 1'($urandom); id_b_sel = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
      stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 9) == 0);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
      #1;
      ea = m.a_sel ? {27'b0, m.shamt} : fwd(m.rs, m.rs_val);
      eb = m.b_sel ? m.imm : fwd(m.rt, m.rt_val);
      es = fwd(m.rt, m.rt_val);
      total++; if (load_use_stall !== exp_lus()) begin bad++;
        $display("FAIL rnd_lus n=%0d got=%0b want=%0b", n, load_use_stall, exp_lus()); end
      total++; if (ex_valid !== m.valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%0b want=%0b", n, ex_valid, m.valid); end
      total++; if (ex_pc !== m.pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h want=%h", n, ex_pc, m.pc); end
      total++; if (ex_alu_a !== ea) begin bad++; $display("FAIL rnd_a n=%0d got=%h want=%h", n, ex_alu_a, ea); end
      total++; if (ex_alu_b !== eb) begin bad++; $display("FAIL rnd_b n=%0d got=%h want=%h", n, ex_alu_b, eb); end
      total++; if (ex_store_data !== es) begin bad++; $display("FAIL rnd_st n=%0d got=%h want=%h", n, ex_store_data, es); end
      total++; if (ex_alu_op !== m.op) begin bad++; $display("FAIL rnd_op n=%0d got=%h want=%h", n, ex_alu_op, m.op); end
      total++; if (ex_rd !== m.rd) begin bad++; $display("FAIL rnd_rd n=%0d got=%0d want=%0d", n, ex_rd, m.rd); end
      total++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== {m.rw, m.mr, m.mw}) begin bad++;
        $display("FAIL rnd_ctrl n=%0d got=%b want=%b", n, {ex_reg_write, ex_mem_read, ex_mem_write}, {m.rw, m.mr, m.mw}); end
      tick();
    end
    rst_n = 1;
    clear_inputs();
  endtask

  initial begin
    m = bubble();
    rst_n = 0;
    clear_inputs();
    #2;
    test_reset();
    test_capture();
    test_forward_priority();
    test_zero_reg();
    test_load_use();
    test_stall_refresh();
    test_imm_shamt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
